// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_controller
// Purpose  : Moore control FSM for the multicycle MIPS datapath. Walks each
//            instruction through fetch / decode / execute / memory /
//            writeback. Every memory state (FETCH, MEM_RD, MEM_WR) is
//            stretched by MEM_WAIT extra cycles. instr_done pulses in the
//            final cycle of each instruction.
// Params   : MEM_WAIT - extra cycles each memory access is held (default 0)
//            WAIT_W   - wait counter width; MEM_WAIT must fit in WAIT_W bits
// Ports    : clk, rst           - clock, synchronous active-high reset
//            opcode, func, zero - IR[31:26], IR[5:0], ALU zero flag
//            pc_write, pc_write_cond, pc_en, pc_src       - PC control
//            i_or_d, mem_read, mem_write, ir_write        - memory / IR
//            reg_dst, mem_to_reg, reg_write               - register file
//            alu_src_a, alu_src_b, alu_op                 - ALU control
//            state, instr_done  - debug state code, retire pulse
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_controller #(
    parameter int MEM_WAIT = 0,
    parameter int WAIT_W   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] func,
    input  logic       zero,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       pc_en,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic [3:0] state,
    output logic       instr_done
);

    // ------------------------------------------------------------------
    // State encoding (codes are visible on the state port)
    // ------------------------------------------------------------------
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EX     = 4'd6,
        S_R_WB     = 4'd7,
        S_BEQ      = 4'd8,
        S_JMP      = 4'd9,
        S_JAL      = 4'd10,
        S_I_EX     = 4'd11,
        S_I_WB     = 4'd12,
        S_JR       = 4'd13
    } state_t;

    // Opcodes
    localparam logic [5:0] C_OP_RTYPE = 6'b000000;
    localparam logic [5:0] C_OP_LW    = 6'b100011;
    localparam logic [5:0] C_OP_SW    = 6'b101011;
    localparam logic [5:0] C_OP_BEQ   = 6'b000100;
    localparam logic [5:0] C_OP_ADDI  = 6'b001001;
    localparam logic [5:0] C_OP_SLTI  = 6'b001010;
    localparam logic [5:0] C_OP_J     = 6'b000010;
    localparam logic [5:0] C_OP_JAL   = 6'b000011;
    localparam logic [5:0] C_OP_JR    = 6'b000110;

    // Field encodings
    localparam logic [1:0] C_SRCB_B     = 2'b00;
    localparam logic [1:0] C_SRCB_4     = 2'b01;
    localparam logic [1:0] C_SRCB_IMM   = 2'b10;
    localparam logic [1:0] C_SRCB_IMMSH = 2'b11;
    localparam logic [1:0] C_ALU_ADD    = 2'b00;
    localparam logic [1:0] C_ALU_SUB    = 2'b01;
    localparam logic [1:0] C_ALU_FUNC   = 2'b10;
    localparam logic [1:0] C_ALU_SLT    = 2'b11;
    localparam logic [1:0] C_PC_ALU     = 2'b00;
    localparam logic [1:0] C_PC_ALUOUT  = 2'b01;
    localparam logic [1:0] C_PC_JUMP    = 2'b10;
    localparam logic [1:0] C_PC_REG     = 2'b11;
    localparam logic [1:0] C_DST_RT     = 2'b00;
    localparam logic [1:0] C_DST_RD     = 2'b01;
    localparam logic [1:0] C_DST_RA     = 2'b10;
    localparam logic [1:0] C_WD_ALUOUT  = 2'b00;
    localparam logic [1:0] C_WD_MDR     = 2'b01;
    localparam logic [1:0] C_WD_PC      = 2'b10;

    // Counter value on the last cycle of a memory state
    localparam logic [WAIT_W-1:0] C_WAIT_LAST = WAIT_W'(MEM_WAIT);

    // ------------------------------------------------------------------
    // Registers and combinational controls
    // ------------------------------------------------------------------
    state_t            r_state;
    state_t            w_next;
    logic [WAIT_W-1:0] r_wait;
    logic              w_mem_state;
    logic              w_mem_last;

    logic       w_pc_write;
    logic       w_pc_write_cond;
    logic       w_i_or_d;
    logic       w_mem_read;
    logic       w_mem_write;
    logic       w_ir_write;
    logic [1:0] w_reg_dst;
    logic [1:0] w_mem_to_reg;
    logic       w_reg_write;
    logic       w_alu_src_a;
    logic [1:0] w_alu_src_b;
    logic [1:0] w_alu_op;
    logic [1:0] w_pc_src;
    logic       w_instr_done;

    // func is decoded by the downstream ALU-control block, not by this FSM
    logic w_unused_func;
    assign w_unused_func = ^func;

    assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEM_RD) ||
                         (r_state == S_MEM_WR);
    assign w_mem_last  = (r_wait == C_WAIT_LAST);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Memory wait counter: counts cycles spent in a memory state and
    // returns to zero on the cycle the state is left.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait <= '0;
        end else if (w_mem_state && !w_mem_last) begin
            r_wait <= r_wait + 1'b1;
        end else begin
            r_wait <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Next state and Moore outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_next          = S_FETCH;
        w_pc_write      = 1'b0;
        w_pc_write_cond = 1'b0;
        w_i_or_d        = 1'b0;
        w_mem_read      = 1'b0;
        w_mem_write     = 1'b0;
        w_ir_write      = 1'b0;
        w_reg_dst       = C_DST_RT;
        w_mem_to_reg    = C_WD_ALUOUT;
        w_reg_write     = 1'b0;
        w_alu_src_a     = 1'b0;
        w_alu_src_b     = C_SRCB_B;
        w_alu_op        = C_ALU_ADD;
        w_pc_src        = C_PC_ALU;
        w_instr_done    = 1'b0;

        case (r_state)
            S_FETCH: begin
                w_mem_read = 1'b1;
                w_i_or_d   = 1'b0;
                if (w_mem_last) begin
                    // Latch IR and advance PC by 4 together
                    w_ir_write  = 1'b1;
                    w_pc_write  = 1'b1;
                    w_alu_src_a = 1'b0;
                    w_alu_src_b = C_SRCB_4;
                    w_alu_op    = C_ALU_ADD;
                    w_pc_src    = C_PC_ALU;
                    w_next      = S_DECODE;
                end else begin
                    w_next = S_FETCH;
                end
            end

            S_DECODE: begin
                // ALUOut <= PC + (sext imm << 2) as a speculative branch target
                w_alu_src_a = 1'b0;
                w_alu_src_b = C_SRCB_IMMSH;
                w_alu_op    = C_ALU_ADD;
                case (opcode)
                    C_OP_RTYPE:           w_next = S_R_EX;
                    C_OP_LW, C_OP_SW:     w_next = S_MEM_ADDR;
                    C_OP_BEQ:             w_next = S_BEQ;
                    C_OP_ADDI, C_OP_SLTI: w_next = S_I_EX;
                    C_OP_J:               w_next = S_JMP;
                    C_OP_JAL:             w_next = S_JAL;
                    C_OP_JR:              w_next = S_JR;
                    default: begin
                        // Unknown opcode retires as a NOP
                        w_next       = S_FETCH;
                        w_instr_done = 1'b1;
                    end
                endcase
            end

            S_MEM_ADDR: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = C_SRCB_IMM;
                w_alu_op    = C_ALU_ADD;
                w_next      = (opcode == C_OP_LW) ? S_MEM_RD : S_MEM_WR;
            end

            S_MEM_RD: begin
                w_mem_read = 1'b1;
                w_i_or_d   = 1'b1;
                w_next     = w_mem_last ? S_MEM_WB : S_MEM_RD;
            end

            S_MEM_WB: begin
                w_reg_write  = 1'b1;
                w_reg_dst    = C_DST_RT;
                w_mem_to_reg = C_WD_MDR;
                w_instr_done = 1'b1;
                w_next       = S_FETCH;
            end

            S_MEM_WR: begin
                w_mem_write = 1'b1;
                w_i_or_d    = 1'b1;
                if (w_mem_last) begin
                    w_instr_done = 1'b1;
                    w_next       = S_FETCH;
                end else begin
                    w_next = S_MEM_WR;
                end
            end

            S_R_EX: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = C_SRCB_B;
                w_alu_op    = C_ALU_FUNC;
                w_next      = S_R_WB;
            end

            S_R_WB: begin
                w_reg_write  = 1'b1;
                w_reg_dst    = C_DST_RD;
                w_mem_to_reg = C_WD_ALUOUT;
                w_instr_done = 1'b1;
                w_next       = S_FETCH;
            end

            S_BEQ: begin
                w_alu_src_a     = 1'b1;
                w_alu_src_b     = C_SRCB_B;
                w_alu_op        = C_ALU_SUB;
                w_pc_write_cond = 1'b1;
                w_pc_src        = C_PC_ALUOUT;
                w_instr_done    = 1'b1;
                w_next          = S_FETCH;
            end

            S_I_EX: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = C_SRCB_IMM;
                w_alu_op    = (opcode == C_OP_SLTI) ? C_ALU_SLT : C_ALU_ADD;
                w_next      = S_I_WB;
            end

            S_I_WB: begin
                w_reg_write  = 1'b1;
                w_reg_dst    = C_DST_RT;
                w_mem_to_reg = C_WD_ALUOUT;
                w_instr_done = 1'b1;
                w_next       = S_FETCH;
            end

            S_JMP: begin
                w_pc_write   = 1'b1;
                w_pc_src     = C_PC_JUMP;
                w_instr_done = 1'b1;
                w_next       = S_FETCH;
            end

            S_JAL: begin
                // PC was already incremented in FETCH, so it is the link value
                w_pc_write   = 1'b1;
                w_pc_src     = C_PC_JUMP;
                w_reg_write  = 1'b1;
                w_reg_dst    = C_DST_RA;
                w_mem_to_reg = C_WD_PC;
                w_instr_done = 1'b1;
                w_next       = S_FETCH;
            end

            S_JR: begin
                w_pc_write   = 1'b1;
                w_pc_src     = C_PC_REG;
                w_instr_done = 1'b1;
                w_next       = S_FETCH;
            end

            default: begin
                // Unused codes recover to FETCH
                w_next = S_FETCH;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs: reset masks every control so an aborted instruction cannot
    // strobe memory or write state in the reset cycle.
    // ------------------------------------------------------------------
    assign pc_write      = w_pc_write      & ~rst;
    assign pc_write_cond = w_pc_write_cond & ~rst;
    assign i_or_d        = w_i_or_d        & ~rst;
    assign mem_read      = w_mem_read      & ~rst;
    assign mem_write     = w_mem_write     & ~rst;
    assign ir_write      = w_ir_write      & ~rst;
    assign reg_dst       = rst ? 2'b00 : w_reg_dst;
    assign mem_to_reg    = rst ? 2'b00 : w_mem_to_reg;
    assign reg_write     = w_reg_write     & ~rst;
    assign alu_src_a     = w_alu_src_a     & ~rst;
    assign alu_src_b     = rst ? 2'b00 : w_alu_src_b;
    assign alu_op        = rst ? 2'b00 : w_alu_op;
    assign pc_src        = rst ? 2'b00 : w_pc_src;
    assign instr_done    = w_instr_done    & ~rst;
    assign pc_en         = pc_write | (pc_write_cond & zero);
    assign state         = r_state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_multicycle_controller
// Purpose  : Self-checking bench. Three controllers (MEM_WAIT = 0, 2, 3) run
//            directed instruction sequences one at a time; the idle ones are
//            held in reset. A per-instruction model expands each opcode into
//            its expected cycle-by-cycle control vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_controller;

    localparam int NI = 3;

    // Packed observation vector layout
    localparam logic [23:0] PCW  = 24'h800000;
    localparam logic [23:0] PCWC = 24'h400000;
    localparam logic [23:0] PCEN = 24'h200000;
    localparam logic [23:0] IORD = 24'h100000;
    localparam logic [23:0] MR   = 24'h080000;
    localparam logic [23:0] MW   = 24'h040000;
    localparam logic [23:0] IRW  = 24'h020000;
    localparam logic [23:0] RW   = 24'h001000;
    localparam logic [23:0] SA   = 24'h000800;
    localparam logic [23:0] STF  = 24'h00001E;
    localparam logic [23:0] DONE = 24'h000001;

    function automatic logic [23:0] f_rdst(input logic [1:0] x); return 24'(x) << 15; endfunction
    function automatic logic [23:0] f_m2r (input logic [1:0] x); return 24'(x) << 13; endfunction
    function automatic logic [23:0] f_sb  (input logic [1:0] x); return 24'(x) << 9;  endfunction
    function automatic logic [23:0] f_aop (input logic [1:0] x); return 24'(x) << 7;  endfunction
    function automatic logic [23:0] f_ps  (input logic [1:0] x); return 24'(x) << 5;  endfunction

    function automatic int wait_of(input int k);
        return (k == 0) ? 0 : ((k == 1) ? 2 : 3);
    endfunction

    logic        clk;
    logic        rst_v  [NI];
    logic [5:0]  op_v   [NI];
    logic        zero_v [NI];
    logic [23:0] obs    [NI];
    logic [5:0]  func_tb;

    int checks   = 0;
    int failures = 0;
    int act      = 0;
    bit started  = 0;

    typedef struct {
        logic [23:0] vec;
        logic [23:0] mask;
    } exp_t;
    exp_t expq[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int W = (g == 0) ? 0 : ((g == 1) ? 2 : 3);
        logic       pcw, pcwc, pcen, iord, mr, mw, irw, rw, sa, done;
        logic [1:0] rdst, m2r, sb, aop, ps;
        logic [3:0] st;

        multicycle_controller #(.MEM_WAIT(W), .WAIT_W(4)) u_dut (
            .clk           (clk),
            .rst           (rst_v[g]),
            .opcode        (op_v[g]),
            .func          (func_tb),
            .zero          (zero_v[g]),
            .pc_write      (pcw),
            .pc_write_cond (pcwc),
            .pc_en         (pcen),
            .i_or_d        (iord),
            .mem_read      (mr),
            .mem_write     (mw),
            .ir_write      (irw),
            .reg_dst       (rdst),
            .mem_to_reg    (m2r),
            .reg_write     (rw),
            .alu_src_a     (sa),
            .alu_src_b     (sb),
            .alu_op        (aop),
            .pc_src        (ps),
            .state         (st),
            .instr_done    (done)
        );

        assign obs[g] = {pcw, pcwc, pcen, iord, mr, mw, irw, rdst, m2r,
                         rw, sa, sb, aop, ps, st, done};
    end

    task automatic chk(input string nm, input int k, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s inst=%0d t=%0t got=%h exp=%h", nm, k, $time, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Model: expand one instruction into its expected per-cycle vectors
    // ------------------------------------------------------------------
    task automatic push(input logic [3:0] st, input logic [23:0] c, input logic z);
        exp_t e;
        e.vec       = c;
        e.vec[21]   = c[23] | (c[22] & z);
        e.vec[4:1]  = st;
        e.mask      = '1;
        expq.push_back(e);
    endtask

    task automatic mem_phase(input int w, input logic [3:0] st, input logic [23:0] every,
                             input logic [23:0] last, input logic z);
        for (int i = 0; i <= w; i++)
            push(st, (i == w) ? (every | last) : every, z);
    endtask

    task automatic model_instr(input int w, input logic [5:0] op, input logic z,
                               output int n);
        int n0;
        n0 = expq.size();
        mem_phase(w, 4'd0, MR, PCW | IRW | f_sb(2'b01), z);
        case (op)
            6'b000000: begin
                push(4'd1, f_sb(2'b11), z);
                push(4'd6, SA | f_aop(2'b10), z);
                push(4'd7, RW | f_rdst(2'b01) | DONE, z);
            end
            6'b100011: begin
                push(4'd1, f_sb(2'b11), z);
                push(4'd2, SA | f_sb(2'b10), z);
                mem_phase(w, 4'd3, MR | IORD, 24'h0, z);
                push(4'd4, RW | f_m2r(2'b01) | DONE, z);
            end
            6'b101011: begin
                push(4'd1, f_sb(2'b11), z);
                push(4'd2, SA | f_sb(2'b10), z);
                mem_phase(w, 4'd5, MW | IORD, DONE, z);
            end
            6'b000100: begin
                push(4'd1, f_sb(2'b11), z);
                push(4'd8, SA | f_aop(2'b01) | PCWC | f_ps(2'b01) | DONE, z);
            end
            6'b001001, 6'b001010: begin
                push(4'd1, f_sb(2'b11), z);
                push(4'd11, SA | f_sb(2'b10) | f_aop((op == 6'b001010) ? 2'b11 : 2'b00), z);
                push(4'd12, RW | DONE, z);
            end
            6'b000010: begin
                push(4'd1, f_sb(2'b11), z);
                push(4'd9, PCW | f_ps(2'b10) | DONE, z);
            end
            6'b000011: begin
                push(4'd1, f_sb(2'b11), z);
                push(4'd10, PCW | f_ps(2'b10) | RW | f_rdst(2'b10) | f_m2r(2'b10) | DONE, z);
            end
            6'b000110: begin
                push(4'd1, f_sb(2'b11), z);
                push(4'd13, PCW | f_ps(2'b11) | DONE, z);
            end
            default: push(4'd1, f_sb(2'b11) | DONE, z);
        endcase
        n = expq.size() - n0;
    endtask

    // ------------------------------------------------------------------
    // Compare process: active instance against the model, idle instances
    // must show all controls low.
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (started) begin
            for (int k = 0; k < NI; k++)
                if (k != act) chk("idle_outputs", k, 32'(obs[k] & ~STF), 32'h0);
            if (expq.size() > 0) begin
                exp_t e;
                e = expq.pop_front();
                chk("cycle_vector", act, 32'(obs[act] & e.mask), 32'(e.vec & e.mask));
            end
        end
    end

    // Run one instruction on instance k starting at a FETCH boundary, with an
    // optional literal spot check at cycle 'spot' (1-based; 0 = none).
    task automatic run_instr(input int k, input logic [5:0] op, input logic z,
                             input int exp_len, input int spot,
                             input logic [23:0] smask, input logic [23:0] sval);
        int n;
        model_instr(wait_of(k), op, z, n);
        chk("model_len", k, 32'(n), 32'(exp_len));
        op_v[k]   = op;
        zero_v[k] = z;
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            if (c == spot) chk("spot", k, 32'(obs[k] & smask), 32'(sval));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic select(input int k);
        rst_v[act] = 1'b1;
        act        = k;
        rst_v[k]   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog inst=%0d got=timeout exp=finish", act);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int target;
        exp_t z;
        func_tb = 6'h20;
        for (int k = 0; k < NI; k++) begin
            rst_v[k]  = 1'b1;
            op_v[k]   = 6'h00;
            zero_v[k] = 1'b0;
        end

        // Reset: two edges with rst high, everything low and state 0
        @(posedge clk); #1;
        started = 1;
        z.vec  = '0;
        z.mask = '1;
        expq.push_back(z);
        @(posedge clk); #1;
        rst_v[0] = 1'b0;

        // MEM_WAIT = 0
        run_instr(0, 6'b000000, 1'b0, 4, 1, MR | IORD, MR);
        run_instr(0, 6'b000000, 1'b0, 4, 4, RW | f_rdst(2'b11) | DONE,
                  RW | f_rdst(2'b01) | DONE);
        run_instr(0, 6'b000100, 1'b1, 3, 3, PCEN, PCEN);
        run_instr(0, 6'b000100, 1'b0, 3, 3, PCEN | PCWC, PCWC);
        run_instr(0, 6'b000011, 1'b0, 3, 3, PCW | f_rdst(2'b11) | f_m2r(2'b11) | f_ps(2'b11),
                  PCW | f_rdst(2'b10) | f_m2r(2'b10) | f_ps(2'b10));
        run_instr(0, 6'b111111, 1'b0, 2, 2, DONE | RW | MW | PCW | IRW, DONE);
        run_instr(0, 6'b101011, 1'b0, 4, 4, MW | DONE, MW | DONE);
        run_instr(0, 6'b001001, 1'b0, 4, 0, '0, '0);
        run_instr(0, 6'b001010, 1'b0, 4, 3, f_aop(2'b11), f_aop(2'b11));
        run_instr(0, 6'b000010, 1'b0, 3, 0, '0, '0);
        run_instr(0, 6'b000110, 1'b0, 3, 3, f_ps(2'b11), f_ps(2'b11));
        run_instr(0, 6'b100011, 1'b0, 5, 5, f_m2r(2'b11), f_m2r(2'b01));

        // MEM_WAIT = 2
        select(1);
        run_instr(1, 6'b100011, 1'b0, 9, 3, IRW, IRW);
        run_instr(1, 6'b100011, 1'b0, 9, 2, IRW | MR, MR);
        run_instr(1, 6'b101011, 1'b0, 8, 6, MW | DONE, MW);
        run_instr(1, 6'b000000, 1'b0, 6, 0, '0, '0);

        // MEM_WAIT = 3, then sw aborted by reset on its 2nd MEM_WR cycle
        select(2);
        run_instr(2, 6'b000000, 1'b0, 7, 4, IRW, IRW);
        model_instr(3, 6'b101011, 1'b0, n);
        chk("model_len", 2, 32'(n), 32'd10);
        target = expq.size() - n + 7;
        while (expq.size() > target) void'(expq.pop_back());
        z.vec  = '0;
        z.mask = ~STF;
        expq.push_back(z);
        op_v[2] = 6'b101011;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            @(posedge clk);
            #1;
        end
        rst_v[2] = 1'b1;
        @(negedge clk);
        chk("abort_mem_write", 2, 32'(obs[2] & (MW | DONE)), 32'h0);
        @(posedge clk); #1;
        rst_v[2] = 1'b0;
        // Counter must restart from zero: IR loads on the 4th FETCH cycle
        run_instr(2, 6'b000000, 1'b0, 7, 4, IRW | STF, IRW);

        chk("queue_drained", act, 32'(expq.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
